// File: rtl/program_loader.sv
// Byte-stream program loader: writes bytes into CPU RAM from address 0, logs
// big-endian 32-bit words, pads the final word with zeros, and gates CPU reset.
module program_loader #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DEPTH  = 256
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   input  logic              byte_last,
   output logic              byte_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_data,
   output logic [31:0]       word_out,
   output logic              word_valid,
   output logic [ADDR_W:0]   byte_count,
   output logic              cpu_hold,
   output logic              done,
   output logic              overflow
);

   localparam int unsigned CW = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, LOAD, PAD, DONE} state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] addr, addr_nx, addr_inc;
   logic [23:0]       shift, shift_nx;
   logic              accept;
   logic              ready_nx, we_nx, wv_nx, hold_nx, done_nx, ovf_nx;
   logic [ADDR_W-1:0] maddr_nx;
   logic [7:0]        mdata_nx;
   logic [31:0]       word_nx;
   logic [CW-1:0]     cnt_nx;

   assign accept = byte_valid & byte_ready;
   // The address saturates at the last RAM byte so it can never wrap to 0.
   assign addr_inc = (addr == LAST_ADDR) ? addr : addr + ADDR_W'(1);

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state      <= IDLE;
         addr       <= '0;
         shift      <= '0;
         byte_ready <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_data   <= '0;
         word_out   <= '0;
         word_valid <= 1'b0;
         byte_count <= '0;
         cpu_hold   <= 1'b1;
         done       <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state      <= state_nx;
         addr       <= addr_nx;
         shift      <= shift_nx;
         byte_ready <= ready_nx;
         mem_we     <= we_nx;
         mem_addr   <= maddr_nx;
         mem_data   <= mdata_nx;
         word_out   <= word_nx;
         word_valid <= wv_nx;
         byte_count <= cnt_nx;
         cpu_hold   <= hold_nx;
         done       <= done_nx;
         overflow   <= ovf_nx;
      end
   end

   always_comb begin
      state_nx = state;
      addr_nx  = addr;
      shift_nx = shift;
      we_nx    = 1'b0;
      maddr_nx = mem_addr;
      mdata_nx = mem_data;
      word_nx  = word_out;
      wv_nx    = 1'b0;
      cnt_nx   = byte_count;
      ovf_nx   = overflow;

      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nx = LOAD;
               addr_nx  = '0;
               cnt_nx   = '0;
               ovf_nx   = 1'b0;
            end
         end
         LOAD: begin
            if (accept) begin
               we_nx    = 1'b1;
               maddr_nx = addr;
               mdata_nx = byte_in;
               cnt_nx   = byte_count + CW'(1);
               shift_nx = {shift[15:0], byte_in};
               addr_nx  = addr_inc;
               if (addr[1:0] == 2'd3) begin
                  wv_nx   = 1'b1;
                  word_nx = {shift, byte_in};
               end
               if (byte_last) begin
                  state_nx = (addr[1:0] == 2'd3) ? DONE : PAD;
               end else if (addr == LAST_ADDR) begin
                  ovf_nx   = 1'b1;
                  state_nx = DONE;
               end
            end
         end
         PAD: begin
            // Zero-fill the tail of the last word, one byte per cycle.
            we_nx    = 1'b1;
            maddr_nx = addr;
            mdata_nx = 8'h00;
            cnt_nx   = byte_count + CW'(1);
            shift_nx = {shift[15:0], 8'h00};
            addr_nx  = addr_inc;
            if (addr[1:0] == 2'd3) begin
               wv_nx    = 1'b1;
               word_nx  = {shift, 8'h00};
               state_nx = DONE;
            end
         end
         default: state_nx = IDLE;
      endcase

      ready_nx = (state_nx == LOAD);
      done_nx  = (state_nx == DONE);
      hold_nx  = (state_nx != DONE);
   end

endmodule
